// File: rtl/mem_map_pkg.sv
// Shared address map, STATUS bit positions and reset constants for mem_responder.
// Timer registers are only decoded when MEM_RESPONDER_TIMER_EN is defined.
package mem_map_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STATUS_W = 4;

  localparam logic [3:0]        RAM_REGION       = 4'h0;
  localparam logic [DATA_W-1:0] REG_GPIO_ADDR    = 32'hF000_0000;
  localparam logic [DATA_W-1:0] REG_TMR_CNT_ADDR = 32'hF000_0004;
  localparam logic [DATA_W-1:0] REG_TMR_CMP_ADDR = 32'hF000_0008;
  localparam logic [DATA_W-1:0] REG_STATUS_ADDR  = 32'hF000_000C;

  localparam int unsigned ST_MISALIGN = 0;
  localparam int unsigned ST_UNMAPPED = 1;
  localparam int unsigned ST_COLLIDE  = 2;
  localparam int unsigned ST_TMR_HIT  = 3;

  localparam logic [DATA_W-1:0] TMR_CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_TCNT,
    SEL_TCMP,
    SEL_STATUS
  } sel_e;

endpackage

// File: rtl/mem_timer.sv
// Free-running 32-bit counter with compare register; hit_c flags the post-update match.
// Instantiated by mem_responder only when MEM_RESPONDER_TIMER_EN is defined.
module mem_timer
  import mem_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_we,
  input  logic              cmp_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] cmp,
  output logic              hit_c
);

  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;

  // A load replaces the increment; compare uses the old cmp so a new value applies next edge.
  always_comb begin
    count_d = count_q + DATA_W'(1);
    cmp_d   = cmp_q;
    if (cnt_we) count_d = wdata;
    if (cmp_we) cmp_d = wdata;
    hit_c = (count_d == cmp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= TMR_CMP_RST;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
    end
  end

  assign count = count_q;
  assign cmp   = cmp_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: word RAM, GPIO register, W1C STATUS and optional timer.
// Define MEM_RESPONDER_TIMER_EN to build the TMR_COUNT/TMR_CMP timer and its IRQ.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [DATA_W-1:0] iMemAddr,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemWrite,
  input  logic              iMemRead,
  output logic [DATA_W-1:0] oMemData,
  output logic [GPIO_W-1:0] oGpio,
  output logic              oIrq
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [29:0] GPIO_WADDR   = REG_GPIO_ADDR[31:2];
  localparam logic [29:0] STATUS_WADDR = REG_STATUS_ADDR[31:2];
`ifdef MEM_RESPONDER_TIMER_EN
  localparam logic [29:0] TCNT_WADDR   = REG_TMR_CNT_ADDR[31:2];
  localparam logic [29:0] TCMP_WADDR   = REG_TMR_CMP_ADDR[31:2];
`endif

  logic [DATA_W-1:0]   ram_q [MEM_WORDS];
  logic [GPIO_W-1:0]   gpio_q, gpio_d;
  logic [STATUS_W-1:0] status_q, status_d;

  sel_e                sel;
  logic [27:0]         ram_hi;
  logic [AW-1:0]       ram_idx;
  logic                misalign, valid, wr_en, access;
  logic [STATUS_W-1:0] set_c, clr_c;
  logic [DATA_W-1:0]   rdata;
  logic                tmr_hit;
`ifdef MEM_RESPONDER_TIMER_EN
  logic [DATA_W-1:0]   tmr_count, tmr_cmp;
`endif

  // Decode; the RAM region is only mapped below MEM_WORDS*4.
  always_comb begin
    ram_idx  = iMemAddr[AW+1:2];
    ram_hi   = iMemAddr[27:0] >> (AW + 2);
    misalign = (iMemAddr[1:0] != 2'b00);
    sel      = SEL_NONE;
    if (iMemAddr[31:28] == RAM_REGION) begin
      if (ram_hi == '0) sel = SEL_RAM;
    end else begin
      case (iMemAddr[31:2])
        GPIO_WADDR:   sel = SEL_GPIO;
`ifdef MEM_RESPONDER_TIMER_EN
        TCNT_WADDR:   sel = SEL_TCNT;
        TCMP_WADDR:   sel = SEL_TCMP;
`endif
        STATUS_WADDR: sel = SEL_STATUS;
        default:      sel = SEL_NONE;
      endcase
    end
    access = iMemRead | iMemWrite;
    valid  = (sel != SEL_NONE) && !misalign;
    wr_en  = iMemWrite && valid;
  end

  // Asynchronous read; a simultaneous write still sees the pre-write contents.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_RAM:    rdata = ram_q[ram_idx];
      SEL_GPIO:   rdata = DATA_W'(gpio_q);
`ifdef MEM_RESPONDER_TIMER_EN
      SEL_TCNT:   rdata = tmr_count;
      SEL_TCMP:   rdata = tmr_cmp;
`endif
      SEL_STATUS: rdata = DATA_W'(status_q);
      default:    rdata = '0;
    endcase
    oMemData = (iMemRead && valid) ? rdata : '0;
  end

`ifdef MEM_RESPONDER_TIMER_EN
  mem_timer u_timer (
    .clk    (iClk),
    .rst    (iRst),
    .cnt_we (wr_en && (sel == SEL_TCNT)),
    .cmp_we (wr_en && (sel == SEL_TCMP)),
    .wdata  (iMemData),
    .count  (tmr_count),
    .cmp    (tmr_cmp),
    .hit_c  (tmr_hit)
  );
`else
  assign tmr_hit = 1'b0;
`endif

  // Error sets win over a W1C clear landing on the same edge.
  always_comb begin
    set_c              = '0;
    set_c[ST_MISALIGN] = access && misalign;
    set_c[ST_UNMAPPED] = access && (sel == SEL_NONE);
    set_c[ST_COLLIDE]  = iMemRead && iMemWrite;
    set_c[ST_TMR_HIT]  = tmr_hit;
    clr_c              = (wr_en && (sel == SEL_STATUS)) ? iMemData[STATUS_W-1:0] : '0;
    status_d           = (status_q & ~clr_c) | set_c;
`ifndef MEM_RESPONDER_TIMER_EN
    status_d[ST_TMR_HIT] = 1'b0;
`endif
    gpio_d = (wr_en && (sel == SEL_GPIO)) ? iMemData[GPIO_W-1:0] : gpio_q;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      gpio_q   <= '0;
      status_q <= '0;
    end else begin
      gpio_q   <= gpio_d;
      status_q <= status_d;
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge iClk) begin
    if (!iRst && wr_en && (sel == SEL_RAM)) ram_q[ram_idx] <= iMemData;
  end

  assign oGpio = gpio_q;
`ifdef MEM_RESPONDER_TIMER_EN
  assign oIrq = status_q[ST_TMR_HIT];
`else
  assign oIrq = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; timer checks follow MEM_RESPONDER_TIMER_EN.
module tb_mem_responder;

  logic        iClk;
  logic        iRst;
  logic [31:0] iMemAddr;
  logic [31:0] iMemData;
  logic        iMemWrite;
  logic        iMemRead;
  logic [31:0] oMemData;
  logic [7:0]  oGpio;
  logic        oIrq;

  int n_tests;
  int n_fail;

  localparam logic [31:0] A_GPIO = 32'hF000_0000;
  localparam logic [31:0] A_TCNT = 32'hF000_0004;
  localparam logic [31:0] A_TCMP = 32'hF000_0008;
  localparam logic [31:0] A_STAT = 32'hF000_000C;

  mem_responder #(.MEM_WORDS(1024), .GPIO_W(8)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iMemAddr  (iMemAddr),
    .iMemData  (iMemData),
    .iMemWrite (iMemWrite),
    .iMemRead  (iMemRead),
    .oMemData  (oMemData),
    .oGpio     (oGpio),
    .oIrq      (oIrq)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge iClk);
    iMemAddr = a; iMemData = d; iMemWrite = 1'b1; iMemRead = 1'b0;
    @(posedge iClk);
    #1;
    iMemWrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge iClk);
    iMemAddr = a; iMemWrite = 1'b0; iMemRead = 1'b1;
    #2;
    d = oMemData;
    @(posedge iClk);
    #1;
    iMemRead = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    iRst = 1'b1; iMemAddr = '0; iMemData = '0; iMemWrite = 1'b0; iMemRead = 1'b0;
    #1;
    check("rst_gpio", 32'(oGpio), 32'h0);
    check("rst_irq", 32'(oIrq), 32'h0);
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
`ifdef MEM_RESPONDER_TIMER_EN
    bus_rd(A_TCNT, rd); check("tcnt_first_edge", rd, 32'h1);
`endif
    bus_rd(A_STAT, rd); check("rst_status", rd, 32'h0);

    // RAM write then read
    bus_wr(32'h0000_0010, 32'hDEAD_BEEF);
    bus_rd(32'h0000_0010, rd); check("ram_rd", rd, 32'hDEAD_BEEF);
    bus_rd(A_STAT, rd); check("ram_status", rd, 32'h0);

    // Misaligned write/read
    bus_wr(32'h0000_0012, 32'h1234_5678);
    bus_rd(32'h0000_0012, rd); check("misalign_rd", rd, 32'h0);
    bus_rd(32'h0000_0010, rd); check("misalign_keep", rd, 32'hDEAD_BEEF);
    bus_rd(A_STAT, rd); check("misalign_status", rd, 32'h1);
    bus_wr(A_STAT, 32'h1);
    bus_rd(A_STAT, rd); check("w1c_misalign", rd, 32'h0);

    // Unmapped: RAM out of range and foreign region
    bus_rd(32'h0000_1000, rd); check("oor_rd", rd, 32'h0);
    bus_rd(A_STAT, rd); check("oor_status", rd, 32'h2);
    bus_wr(A_STAT, 32'h2);
    bus_rd(32'h8000_0000, rd); check("unmap_rd", rd, 32'h0);
    bus_rd(A_STAT, rd); check("unmap_status", rd, 32'h2);
    bus_wr(A_STAT, 32'hF);
    bus_rd(32'hF000_0010, rd); check("reg_gap_rd", rd, 32'h0);
    bus_rd(A_STAT, rd); check("reg_gap_status", rd, 32'h2);
    bus_wr(A_STAT, 32'hF);

    // Collision: read sees old data, write lands
    bus_wr(32'h0000_0020, 32'h11);
    @(negedge iClk);
    iMemAddr = 32'h0000_0020; iMemData = 32'h22; iMemRead = 1'b1; iMemWrite = 1'b1;
    #2;
    check("collide_old", oMemData, 32'h11);
    @(posedge iClk);
    #1;
    iMemRead = 1'b0; iMemWrite = 1'b0;
    bus_rd(32'h0000_0020, rd); check("collide_new", rd, 32'h22);
    bus_rd(A_STAT, rd); check("collide_status", rd, 32'h4);
    bus_wr(A_STAT, 32'hF);

    // Set beats clear: collide on STATUS clearing bits 0 and 2
    bus_wr(32'h0000_0013, 32'h0);
    @(negedge iClk);
    iMemAddr = A_STAT; iMemData = 32'h5; iMemRead = 1'b1; iMemWrite = 1'b1;
    #2;
    check("stat_collide_old", oMemData, 32'h1);
    @(posedge iClk);
    #1;
    iMemRead = 1'b0; iMemWrite = 1'b0;
    bus_rd(A_STAT, rd); check("set_wins", rd, 32'h4);
    bus_wr(A_STAT, 32'hF);

    // GPIO
    bus_wr(A_GPIO, 32'h0000_01A5);
    check("gpio_out", 32'(oGpio), 32'hA5);
    bus_rd(A_GPIO, rd); check("gpio_rd", rd, 32'hA5);

`ifdef MEM_RESPONDER_TIMER_EN
    bus_wr(A_TCMP, 32'd100);
    bus_wr(A_TCNT, 32'd95);
    check("irq_low_95", 32'(oIrq), 32'h0);
    repeat (4) @(posedge iClk);
    #1;
    check("irq_low_99", 32'(oIrq), 32'h0);
    @(posedge iClk);
    #1;
    check("irq_high_100", 32'(oIrq), 32'h1);
    repeat (10) @(posedge iClk);
    #1;
    check("irq_sticky", 32'(oIrq), 32'h1);
    bus_rd(A_STAT, rd); check("hit_status", rd, 32'h8);
    bus_wr(A_STAT, 32'h8);
    check("irq_cleared", 32'(oIrq), 32'h0);
    bus_rd(A_TCMP, rd); check("tcmp_rd", rd, 32'd100);
    bus_wr(A_TCNT, 32'hFFFF_FFFE);
    bus_rd(A_TCNT, rd); check("wrap_fe", rd, 32'hFFFF_FFFE);
    bus_rd(A_TCNT, rd); check("wrap_ff", rd, 32'hFFFF_FFFF);
    bus_rd(A_TCNT, rd); check("wrap_zero", rd, 32'h0);
`else
    bus_rd(A_TCNT, rd); check("tcnt_unmapped", rd, 32'h0);
    bus_rd(A_STAT, rd); check("tcnt_status", rd, 32'h2);
    bus_wr(A_STAT, 32'hF);
    bus_wr(A_TCMP, 32'd3);
    bus_rd(A_STAT, rd); check("tcmp_status", rd, 32'h2);
    bus_wr(A_STAT, 32'hF);
    check("irq_tied", 32'(oIrq), 32'h0);
`endif

    // Asynchronous reset mid-cycle during a RAM write
    bus_wr(A_GPIO, 32'hA5);
    @(negedge iClk);
    iMemAddr = 32'h0000_0010; iMemData = 32'h5555_5555; iMemWrite = 1'b1;
    #2;
    iRst = 1'b1;
    #1;
    check("arst_gpio", 32'(oGpio), 32'h0);
    check("arst_irq", 32'(oIrq), 32'h0);
    @(posedge iClk);
    #1;
    iMemWrite = 1'b0;
`ifdef MEM_RESPONDER_TIMER_EN
    iMemAddr = A_TCNT; iMemRead = 1'b1;
    #1;
    check("arst_tcnt", oMemData, 32'h0);
    iMemRead = 1'b0;
`endif
    @(negedge iClk);
    iRst = 1'b0;
    bus_rd(32'h0000_0010, rd); check("arst_ram_keep", rd, 32'hDEAD_BEEF);
    bus_rd(A_STAT, rd); check("arst_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, RAM depth in 32-bit words; power of two, 16..65536.
REQ-002 Parameter GPIO_W, default 8, width of the GPIO output register.
REQ-003 iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 iRst  input  1  reset; asynchronous and active-high.
REQ-005 iMemAddr  input  32  byte address from the CPU initiator.
REQ-006 iMemData  input  32  write data from the CPU.
REQ-007 iMemWrite  input  1  write strobe, sampled on the rising edge.
REQ-008 iMemRead  input  1  read strobe.
REQ-009 oMemData  output  32  read data, combinational, valid in the same cycle as iMemRead.
REQ-010 oGpio  output  GPIO_W  GPIO register contents.
REQ-011 oIrq  output  1  high while STATUS.TMR_HIT is set.

Function
REQ-012 Decode rules: address bits [31:28]==0x0 select the RAM region; addresses 0xF000_0000 through 0xF000_000C select registers; all other addresses are unmapped.
REQ-013 Register map: GPIO at 0xF000_0000 (RW); TMR_COUNT at 0xF000_0004 (RW); TMR_CMP at 0xF000_0008 (RW); STATUS at 0xF000_000C (W1C).
REQ-014 STATUS bits: [0] MISALIGN, [1] UNMAPPED (includes RAM out of range), [2] COLLIDE, [3] TMR_HIT; bits [31:4] read 0.
REQ-015 RAM index is iMemAddr[log2(MEM_WORDS)+1:2]; a RAM-region address >= MEM_WORDS*4 counts as unmapped.
REQ-016 Read: when iMemRead=1 and the address is valid, oMemData shall carry the addressed word combinationally with zero latency.
REQ-017 When iMemRead=0 or the access is invalid, oMemData shall be 0.
REQ-018 Write: when iMemWrite=1 and the address is valid, the target shall update at the rising edge; the new value is readable in the next cycle.
REQ-019 Misaligned access (iMemAddr[1:0]!=0): a write is dropped, a read returns 0, and STATUS.MISALIGN is set at the edge.
REQ-020 Unmapped access: a write is dropped, a read returns 0, and STATUS.UNMAPPED is set.
REQ-021 iMemRead and iMemWrite both high: the write proceeds, oMemData returns the pre-write value, and STATUS.COLLIDE is set.
REQ-022 A STATUS write clears each bit written as 1; an error set at the same edge as its clear wins (the bit stays 1).
REQ-023 TMR_COUNT shall increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-024 A write to TMR_COUNT loads iMemData in place of that cycle's increment.
REQ-025 When the post-update TMR_COUNT equals TMR_CMP, STATUS.TMR_HIT shall be set; it is sticky until W1C, and a set at the same edge as a clear wins.
REQ-026 A write to TMR_CMP takes effect for the comparison at the following edge.
REQ-027 oIrq shall equal STATUS[3] as a registered output, with no combinational path from the inputs.

Reset
REQ-028 Asserting iRst shall immediately set GPIO=0, TMR_COUNT=0, TMR_CMP=0xFFFF_FFFF, STATUS=0 and oIrq=0.
REQ-029 RAM contents are not reset; a reset mid-write shall drop that write.
REQ-030 On the first rising edge after iRst deasserts, TMR_COUNT shall become 1.

Configuration
REQ-031 Macro MEM_RESPONDER_TIMER_EN: when defined, the timer (REQ-023..027) is built in.
REQ-032 When MEM_RESPONDER_TIMER_EN is undefined: TMR_COUNT and TMR_CMP become unmapped (reads 0, STATUS.UNMAPPED set), STATUS[3] reads 0, oIrq is tied to 0, and no timer flops are synthesized.

Structure
REQ-033 A shared package or include file, mem_map_pkg, shall hold the region and register address constants, STATUS bit indices, and the TMR_CMP reset value.
REQ-034 Sub-module mem_timer holds the counter, compare register and hit-pulse logic; it is instantiated only under MEM_RESPONDER_TIMER_EN.
REQ-035 The RAM shall be a reg array inferred inside mem_responder, with asynchronous read and synchronous write.

Verification
REQ-036 Write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 in the next cycle -> oMemData=0xDEAD_BEEF in the same cycle as the read; STATUS=0.
REQ-037 Write to 0x0000_0012, then read 0x0000_0012 -> RAM word 4 is unchanged, the read returns 0, and STATUS=0x1; then write 0x1 to STATUS -> STATUS=0.
REQ-038 With MEM_WORDS=1024, read 0x0000_1000 -> 0 and STATUS[1]=1; read 0x8000_0000 -> 0 and STATUS[1]=1.
REQ-039 Drive read and write together on 0x0000_0020 (old value 0x11, new value 0x22) -> oMemData=0x11 in that cycle, the next read returns 0x22, and STATUS[2]=1.
REQ-040 With the timer enabled: write TMR_CMP=100 and TMR_COUNT=95 -> oIrq rises once TMR_COUNT reaches 100 and stays high until 0x8 is written to STATUS; load 0xFFFF_FFFE and confirm the count wraps to 0.
REQ-041 Write GPIO=0xA5, then assert iRst asynchronously mid-cycle -> oGpio=0 and TMR_COUNT=0 immediately, and RAM word 4 retains its prior value.
